sram_responder: RTL
===================

Name: sram_responder

Overview:
Memory-side responder for the arbiter's shared memory bus. It takes the granted request (cs, rwbar, address, write data) and runs a timed access on the board's external asynchronous 32-bit SRAM. It returns read data and a one-cycle ready pulse to the arbiter and caches. It replaces the behavioural SRAM model for the board build, and it completes requests flagged by addr_decode (skip_wait) without touching the SRAM.

Parameters:
MEM_ADDR_WIDTH, 18, word-address width to SRAM (256K x 32).
RD_WAIT, 2, cycles OE asserted before read data is captured; must be >= 1.
WR_WAIT, 2, cycles WE low per write pulse; must be >= 1.

Ports:
clk  in  1  system clock; single clock domain, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
cs  in  1  memory select from arbiter; request present.
rwbar  in  1  1 = read, 0 = write; sampled with cs.
skip_wait  in  1  from addr_decode; address is a device region, do not access SRAM.
adbus  in  MEM_ADDR_WIDTH  word address, sampled with cs.
wdata  in  32  write data, sampled with cs.
rdata  out  32  read data; valid when ready=1 on a read.
ready  out  1  one-cycle completion pulse to arbiter.
busy  out  1  high whenever state != IDLE.
sram_addr  out  MEM_ADDR_WIDTH  SRAM address.
sram_dq_out  out  32  data driven to SRAM.
sram_dq_oe  out  1  tristate enable for sram_dq_out (1 = drive).
sram_dq_in  in  32  data from SRAM pins.
sram_ce_n  out  1  chip enable, active low.
sram_oe_n  out  1  output enable, active low.
sram_we_n  out  1  write enable, active low.

Behaviour:
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- Reset (synchronous) forces: state IDLE, ready=0, rdata=0, sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0, wait counter=0.
- All SRAM control outputs and ready are registered, with no combinational path from inputs.
- IDLE: on cs=1, latch adbus, wdata and rwbar, then branch:
  - skip_wait=1: go to DONE directly; no strobes; rdata is unchanged.
  - rwbar=1: go to RD.
  - rwbar=0: go to WR_SETUP.
- RD: ce_n=0, oe_n=0, dq_oe=0, for RD_WAIT cycles (counter). On the final RD cycle's edge, capture sram_dq_in into rdata, then go to DONE with ce_n=1 and oe_n=1.
- WR_SETUP: 1 cycle; ce_n=0, dq_oe=1, addr and data driven, we_n=1.
- WR_PULSE: WR_WAIT cycles with we_n=0.
- WR_HOLD: 1 cycle with we_n=1 while addr and data are still driven and ce_n=0. Then go to DONE with dq_oe=0 and ce_n=1.
- DONE: ready=1 for exactly this cycle, then IDLE. cs seen during DONE is not a new request.
- Latency, with cs sampled high at the edge ending cycle 0:
  - read: ready in cycle RD_WAIT+1;
  - write: ready in cycle WR_WAIT+3;
  - skip_wait: ready in cycle 1.
- cs may stay high through DONE. A request held high into the following IDLE cycle starts a new transaction, so back-to-back transfers have 1 IDLE cycle between them.
- cs or skip_wait deasserting mid-transaction is ignored; a started write always completes its full pulse and hold. Inputs are only sampled in IDLE.
- rdata holds its value until the next read capture, and is unaffected by writes and skip_wait transfers.
- Reset mid-transaction: state returns to IDLE the cycle after rst is sampled.
  - we_n, oe_n and ce_n go high and dq_oe goes low on that same edge.
  - No ready pulse is produced for the aborted transaction.
- we_n and oe_n are never low simultaneously. dq_oe is never 1 while oe_n=0.

Test Plan:
- Read, RD_WAIT=2, sram_dq_in=0xDEADBEEF, adbus=0x00123 -> sram_addr=0x00123, oe_n low for cycles 1-2, ready=1 in cycle 3, rdata=0xDEADBEEF, ready low in cycle 4.
- Write, WR_WAIT=2, adbus=0x3FFFF, wdata=0xA5A55A5A -> WR_SETUP cycle 1, we_n low cycles 2-3, hold cycle 4 with dq_oe=1, ready in cycle 5; SRAM model contains 0xA5A55A5A at 0x3FFFF.
- skip_wait=1 read with rdata previously 0x12345678 -> ready in cycle 1; ce_n, oe_n and we_n stay 1 throughout; rdata stays 0x12345678.
- Back-to-back write 0xCAFEF00D then read at 0x00010, with cs held high -> one IDLE cycle between the ready pulses; read returns 0xCAFEF00D.
- rst asserted during cycle 2 of a WR_PULSE -> we_n=1, dq_oe=0, ce_n=1 on the next edge; no ready pulse; busy=0.
- cs dropped after 1 cycle of a read -> transaction still completes, with ready in cycle RD_WAIT+1; an assertion checker confirms we_n and oe_n are never both 0 across all scenarios.

Source files
------------

// File: rtl/sram_responder.sv
// Memory-side responder: runs timed accesses on an external asynchronous 32-bit SRAM
// for the arbiter's shared bus, returning read data and a one-cycle ready pulse.
module sram_responder #(
  parameter int unsigned MEM_ADDR_WIDTH = 18,
  parameter int unsigned RD_WAIT        = 2,
  parameter int unsigned WR_WAIT        = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cs,
  input  logic                      rwbar,
  input  logic                      skip_wait,
  input  logic [MEM_ADDR_WIDTH-1:0] adbus,
  input  logic [31:0]               wdata,
  output logic [31:0]               rdata,
  output logic                      ready,
  output logic                      busy,
  output logic [MEM_ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]               sram_dq_out,
  output logic                      sram_dq_oe,
  input  logic [31:0]               sram_dq_in,
  output logic                      sram_ce_n,
  output logic                      sram_oe_n,
  output logic                      sram_we_n
);

  localparam int unsigned CNT_MAX = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_t;

  state_t                    r_state;
  logic [CW-1:0]             r_cnt;
  logic [31:0]               r_rdata;
  logic                      r_ready;
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic [31:0]               r_dout;
  logic                      r_dq_oe;
  logic                      r_ce_n;
  logic                      r_oe_n;
  logic                      r_we_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_addr  <= '0;
      r_dout  <= '0;
      r_dq_oe <= 1'b0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cs) begin
            r_addr <= adbus;
            r_dout <= wdata;
            if (skip_wait) begin
              r_state <= DONE;
              r_ready <= 1'b1;
            end else if (rwbar) begin
              r_state <= RD;
              r_ce_n  <= 1'b0;
              r_oe_n  <= 1'b0;
              r_cnt   <= RD_LOAD;
            end else begin
              r_state <= WR_SETUP;
              r_ce_n  <= 1'b0;
              r_dq_oe <= 1'b1;
            end
          end
        end
        RD: begin
          // Capture on the edge that ends the last OE cycle, strobes release together.
          if (r_cnt == '0) begin
            r_rdata <= sram_dq_in;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        WR_SETUP: begin
          r_we_n  <= 1'b0;
          r_cnt   <= WR_LOAD;
          r_state <= WR_PULSE;
        end
        WR_PULSE: begin
          if (r_cnt == '0) begin
            r_we_n  <= 1'b1;
            r_state <= WR_HOLD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        WR_HOLD: begin
          r_dq_oe <= 1'b0;
          r_ce_n  <= 1'b1;
          r_ready <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_dq_oe <= 1'b0;
          r_ce_n  <= 1'b1;
          r_oe_n  <= 1'b1;
          r_we_n  <= 1'b1;
        end
      endcase
    end
  end

  assign rdata       = r_rdata;
  assign ready       = r_ready;
  assign busy        = (r_state != IDLE);
  assign sram_addr   = r_addr;
  assign sram_dq_out = r_dout;
  assign sram_dq_oe  = r_dq_oe;
  assign sram_ce_n   = r_ce_n;
  assign sram_oe_n   = r_oe_n;
  assign sram_we_n   = r_we_n;

endmodule
